// File: rtl/icb_alu_pkg.sv
// rtl/icb_alu_pkg.sv - register offsets, CTRL bit positions and channel states for icb_alu_acc
package icb_alu_pkg;

  localparam logic [3:0] OFF_OPA     = 4'h0;
  localparam logic [3:0] OFF_OPB     = 4'h4;
  localparam logic [3:0] OFF_CTRL    = 4'h8;
  localparam logic [3:0] OFF_RESULT  = 4'hC;
  localparam logic [7:0] ADDR_STATUS = 8'h80;

  localparam int CTRL_START  = 0;
  localparam int CTRL_CLEAR  = 1;
  localparam int CTRL_SUB    = 2;
  localparam int CTRL_ACC    = 3;
  localparam int CTRL_IRQ_EN = 4;
  localparam int CTRL_SAT    = 5;
  localparam int CTRL_BUSY   = 8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  function automatic logic [31:0] merge_wmask(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  wmask);
    logic [31:0] m;
    m = {{8{wmask[3]}}, {8{wmask[2]}}, {8{wmask[1]}}, {8{wmask[0]}}};
    return (old_val & ~m) | (new_val & m);
  endfunction

endpackage

// File: rtl/icb_alu_core.sv
// rtl/icb_alu_core.sv - shared DW-bit add/sub/saturate datapath; the granted channel's RESULT
// register in the top is its output stage, so a grant completes in one cycle.
module icb_alu_core #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          sub,
  input  logic          sat,
  output logic [DW-1:0] result,
  output logic          ovf
);

  logic [DW:0] sum;
  logic [DW:0] diff;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} - {1'b0, b};
    // bit DW is carry-out for add and borrow for subtract
    ovf    = sub ? diff[DW] : sum[DW];
    result = sub ? diff[DW-1:0] : sum[DW-1:0];
    if (sat && ovf) result = sub ? '0 : '1;
  end

endmodule

// File: rtl/icb_alu_acc.sv
// rtl/icb_alu_acc.sv - NCH-channel ICB add/sub/accumulate peripheral with round-robin shared ALU
// Optional saturation (CTRL bit5) is built only when ICB_ALU_SAT_EN is defined.
module icb_alu_acc
  import icb_alu_pkg::*;
#(
  parameter int DW  = 32,
  parameter int NCH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        icb_cmd_valid,
  output logic        icb_cmd_ready,
  input  logic        icb_cmd_read,
  input  logic [31:0] icb_cmd_addr,
  input  logic [31:0] icb_cmd_wdata,
  input  logic [3:0]  icb_cmd_wmask,
  output logic        icb_rsp_valid,
  input  logic        icb_rsp_ready,
  output logic [31:0] icb_rsp_rdata,
  output logic        icb_rsp_err,
  output logic        irq
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [DW-1:0]  opa    [NCH];
  logic [DW-1:0]  opb    [NCH];
  logic [DW-1:0]  result [NCH];
  logic [0:0]     st     [NCH];
  logic [NCH-1:0] ctrl_sub, ctrl_acc, ctrl_irq_en, ctrl_sat;
  logic [NCH-1:0] done, ovf, pend;
  logic [CW-1:0]  rr_ptr, gnt_idx, next_ptr;
  logic           gnt_valid;

  logic [7:0]  addr;
  logic [2:0]  ch_idx;
  logic [3:0]  off;
  logic        is_status, is_chan, cmd_err, cmd_fire, wr_en, status_wr;
  logic [31:0] rd_data;
  logic [NCH-1:0] wr_opa, wr_opb, wr_ctrl, start_req, clear_req, w1c_done, w1c_ovf;
  logic        unused_addr_hi;

  logic [DW-1:0] core_a, core_b, core_result;
  logic          core_sub, core_sat, core_ovf;

  assign addr           = icb_cmd_addr[7:0];
  assign unused_addr_hi = ^icb_cmd_addr[31:8];
  assign ch_idx         = addr[6:4];
  assign off            = addr[3:0];
  assign is_status      = (addr == ADDR_STATUS);
  assign is_chan        = !addr[7] && (int'(ch_idx) < NCH) && (off[1:0] == 2'b00);
  assign cmd_err        = !(is_status || is_chan) ||
                          (!icb_cmd_read && is_chan && off == OFF_RESULT);

  assign icb_cmd_ready = !icb_rsp_valid || icb_rsp_ready;
  assign cmd_fire      = icb_cmd_valid && icb_cmd_ready;
  assign wr_en         = cmd_fire && !icb_cmd_read && !cmd_err;
  assign status_wr     = wr_en && is_status;
  assign w1c_done      = (status_wr && icb_cmd_wmask[0]) ? icb_cmd_wdata[NCH-1:0] : '0;
  assign w1c_ovf       = (status_wr && icb_cmd_wmask[1]) ? icb_cmd_wdata[NCH+7:8] : '0;

  assign irq = |(done & ctrl_irq_en);

  always_comb begin
    wr_opa = '0; wr_opb = '0; wr_ctrl = '0; start_req = '0; clear_req = '0;
    for (int c = 0; c < NCH; c++) begin
      if (wr_en && is_chan && int'(ch_idx) == c) begin
        wr_opa[c]  = (off == OFF_OPA);
        wr_opb[c]  = (off == OFF_OPB);
        wr_ctrl[c] = (off == OFF_CTRL);
      end
      clear_req[c] = wr_ctrl[c] && icb_cmd_wmask[0] && icb_cmd_wdata[CTRL_CLEAR];
      start_req[c] = wr_ctrl[c] && icb_cmd_wmask[0] && icb_cmd_wdata[CTRL_START];
      pend[c]      = (st[c] == ST_PEND);
    end
  end

  always_comb begin
    rd_data = '0;
    if (is_status) begin
      rd_data[NCH-1:0] = done;
      rd_data[NCH+7:8] = ovf;
    end else if (is_chan) begin
      for (int c = 0; c < NCH; c++) begin
        if (int'(ch_idx) == c) begin
          case (off)
            OFF_OPA:    rd_data = 32'(opa[c]);
            OFF_OPB:    rd_data = 32'(opb[c]);
            OFF_CTRL: begin
              rd_data[CTRL_SUB]    = ctrl_sub[c];
              rd_data[CTRL_ACC]    = ctrl_acc[c];
              rd_data[CTRL_IRQ_EN] = ctrl_irq_en[c];
              rd_data[CTRL_SAT]    = ctrl_sat[c];
              rd_data[CTRL_BUSY]   = pend[c];
            end
            OFF_RESULT: rd_data = 32'(result[c]);
            default:    rd_data = '0;
          endcase
        end
      end
    end
  end

  // Rotated priority search: the first pending channel at or after rr_ptr wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < NCH; i++) begin
      for (int c = 0; c < NCH; c++) begin
        if (!gnt_valid && pend[c] && c == (int'(rr_ptr) + i) % NCH) begin
          gnt_valid = 1'b1;
          gnt_idx   = CW'(c);
        end
      end
    end
  end

  assign next_ptr = CW'((int'(gnt_idx) + 1) % NCH);

  always_comb begin
    core_a = '0; core_b = '0; core_sub = 1'b0; core_sat = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (int'(gnt_idx) == c) begin
        core_a   = ctrl_acc[c] ? result[c] : opa[c];
        core_b   = opb[c];
        core_sub = ctrl_sub[c];
        core_sat = ctrl_sat[c];
      end
    end
  end

  icb_alu_core #(.DW(DW)) u_core (
    .a      (core_a),
    .b      (core_b),
    .sub    (core_sub),
    .sat    (core_sat),
    .result (core_result),
    .ovf    (core_ovf)
  );

`ifndef ICB_ALU_SAT_EN
  assign ctrl_sat = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        opa[c]    <= '0;
        opb[c]    <= '0;
        result[c] <= '0;
        st[c]     <= ST_IDLE;
      end
      ctrl_sub    <= '0;
      ctrl_acc    <= '0;
      ctrl_irq_en <= '0;
`ifdef ICB_ALU_SAT_EN
      ctrl_sat    <= '0;
`endif
      done        <= '0;
      ovf         <= '0;
      rr_ptr      <= '0;
    end else begin
      if (gnt_valid) rr_ptr <= next_ptr;
      for (int c = 0; c < NCH; c++) begin
        if (wr_opa[c]) opa[c] <= DW'(merge_wmask(32'(opa[c]), icb_cmd_wdata, icb_cmd_wmask));
        if (wr_opb[c]) opb[c] <= DW'(merge_wmask(32'(opb[c]), icb_cmd_wdata, icb_cmd_wmask));
        if (wr_ctrl[c] && icb_cmd_wmask[0]) begin
          ctrl_sub[c]    <= icb_cmd_wdata[CTRL_SUB];
          ctrl_acc[c]    <= icb_cmd_wdata[CTRL_ACC];
          ctrl_irq_en[c] <= icb_cmd_wdata[CTRL_IRQ_EN];
`ifdef ICB_ALU_SAT_EN
          ctrl_sat[c]    <= icb_cmd_wdata[CTRL_SAT];
`endif
        end
        // CLEAR overrides a grant or START landing in the same cycle
        if (clear_req[c]) begin
          st[c]     <= ST_IDLE;
          result[c] <= '0;
          done[c]   <= 1'b0;
          ovf[c]    <= 1'b0;
        end else begin
          if (gnt_valid && int'(gnt_idx) == c) begin
            st[c]     <= ST_IDLE;
            result[c] <= core_result;
          end else if (start_req[c] && st[c] == ST_IDLE) begin
            st[c] <= ST_PEND;
          end
          if (gnt_valid && int'(gnt_idx) == c) done[c] <= 1'b1;
          else if (w1c_done[c])                 done[c] <= 1'b0;
          if (gnt_valid && int'(gnt_idx) == c && core_ovf) ovf[c] <= 1'b1;
          else if (w1c_ovf[c])                              ovf[c] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icb_rsp_valid <= 1'b0;
      icb_rsp_rdata <= '0;
      icb_rsp_err   <= 1'b0;
    end else if (cmd_fire) begin
      icb_rsp_valid <= 1'b1;
      icb_rsp_rdata <= (icb_cmd_read && !cmd_err) ? rd_data : 32'h0;
      icb_rsp_err   <= cmd_err;
    end else if (icb_rsp_ready) begin
      icb_rsp_valid <= 1'b0;
    end
  end

endmodule
